// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge_if
// Description : Request, status and two-slave APB signals of the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] apb_write_paddr;
    logic [ADDR_WIDTH-1:0] apb_read_paddr;
    logic [DATA_WIDTH-1:0] apb_write_data;
    logic [DATA_WIDTH-1:0] apb_read_data_out;
    logic                  xfer_done;
    logic                  xfer_err;
    logic                  psel1;
    logic                  psel2;
    logic                  penable;
    logic [ADDR_WIDTH-2:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata1;
    logic [DATA_WIDTH-1:0] prdata2;
    logic                  pready1;
    logic                  pready2;
    logic                  pslverr1;
    logic                  pslverr2;

    // Bridge side
    modport master (
        input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        input  prdata1, prdata2, pready1, pready2, pslverr1, pslverr2,
        output apb_read_data_out, xfer_done, xfer_err,
        output psel1, psel2, penable, paddr, pwrite, pwdata
    );

    // Requester and slave-memory side
    modport slave (
        output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        output prdata1, prdata2, pready1, pready2, pslverr1, pslverr2,
        input  apb_read_data_out, xfer_done, xfer_err,
        input  psel1, psel2, penable, paddr, pwrite, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : APB3 master turning single requests into cycles on two slaves.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_master_bridge_if.master  bus
);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                state_q;
    logic [c_CNT_W-1:0]    cnt_q;
    logic                  psel1_q;
    logic                  psel2_q;
    logic                  penable_q;
    logic [ADDR_WIDTH-2:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  done_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_timeout;
    logic                  w_end;
    logic                  w_capture;

    assign w_req_addr  = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
    // psel2_q alone identifies the slave while in ACCESS
    assign w_sel_ready = psel2_q ? bus.pready2  : bus.pready1;
    assign w_sel_err   = psel2_q ? bus.pslverr2 : bus.pslverr1;
    assign w_sel_rdata = psel2_q ? bus.prdata2  : bus.prdata1;
    assign w_timeout   = (cnt_q == c_CNT_MAX);
    assign w_end       = (state_q == S_ACCESS) && (w_sel_ready || w_timeout);
    assign w_capture   = bus.transfer && ((state_q == S_IDLE) || w_end);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    psel1_q   <= 1'b0;
                    psel2_q   <= 1'b0;
                    penable_q <= 1'b0;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_end) begin
                        done_q <= 1'b1;
                        err_q  <= w_sel_ready ? w_sel_err : 1'b1;
                        if (w_sel_ready && !w_sel_err && !pwrite_q) begin
                            rdata_q <= w_sel_rdata;
                        end
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    psel1_q   <= 1'b0;
                    psel2_q   <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase

            // A new request overrides the return to IDLE, chaining straight into SETUP
            if (w_capture) begin
                psel1_q   <= ~w_req_addr[ADDR_WIDTH-1];
                psel2_q   <=  w_req_addr[ADDR_WIDTH-1];
                penable_q <= 1'b0;
                paddr_q   <= w_req_addr[ADDR_WIDTH-2:0];
                pwrite_q  <= ~bus.READ_WRITE;
                pwdata_q  <= bus.READ_WRITE ? '0 : bus.apb_write_data;
                cnt_q     <= '0;
                state_q   <= S_SETUP;
            end
        end
    end

    assign bus.psel1             = psel1_q;
    assign bus.psel2             = psel2_q;
    assign bus.penable           = penable_q;
    assign bus.paddr             = paddr_q;
    assign bus.pwrite            = pwrite_q;
    assign bus.pwdata            = pwdata_q;
    assign bus.apb_read_data_out = rdata_q;
    assign bus.xfer_done         = done_q;
    assign bus.xfer_err          = err_q;
endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 master stage that converts the testbench-facing request signals into APB bus cycles for two slaves.
- Request signals: transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data.
- Bus outputs: PSEL1/PSEL2, PENABLE, PADDR, PWRITE, PWDATA.
- Returns read data on apb_read_data_out, plus per-transfer completion and error status.
- Sits directly between the driver/monitor interface and the two APB slave memories.

Parameters:
ADDR_WIDTH, 9, request address width; MSB selects the slave, lower ADDR_WIDTH-1 bits drive PADDR
DATA_WIDTH, 8, read and write data width
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before the transfer is aborted with an error

Ports:
pclk  input  1  APB clock
presetn  input  1  asynchronous active-low reset
transfer  input  1  request valid; sampled in IDLE and on ACCESS completion
READ_WRITE  input  1  1 = read, 0 = write
apb_write_paddr  input  ADDR_WIDTH  write address
apb_read_paddr  input  ADDR_WIDTH  read address
apb_write_data  input  DATA_WIDTH  write data
apb_read_data_out  output  DATA_WIDTH  last completed read data
xfer_done  output  1  one-cycle pulse when a transfer ends
xfer_err  output  1  one-cycle pulse with xfer_done; PSLVERR seen or timeout
psel1  output  1  slave 1 select (address MSB = 0)
psel2  output  1  slave 2 select (address MSB = 1)
penable  output  1  APB enable
paddr  output  ADDR_WIDTH-1  APB address
pwrite  output  1  APB write
pwdata  output  DATA_WIDTH  APB write data
prdata1  input  DATA_WIDTH  slave 1 read data
prdata2  input  DATA_WIDTH  slave 2 read data
pready1  input  1  slave 1 ready
pready2  input  1  slave 2 ready
pslverr1  input  1  slave 1 error
pslverr2  input  1  slave 2 error

Behaviour:
- Reset (presetn low, asynchronous):
  - All outputs 0; state = IDLE; timeout counter = 0.
  - Takes effect immediately, including mid-transfer; the in-flight transfer is dropped and no xfer_done is issued.
- Registered outputs: every output is driven from a flop; no combinational path from input to output.
- State machine:
  - IDLE: psel1/psel2/penable = 0.
    - If transfer=1, capture the request and go to SETUP.
    - Captured address = apb_read_paddr if READ_WRITE=1, else apb_write_paddr.
    - Capture READ_WRITE and apb_write_data at the same edge.
  - SETUP (exactly 1 cycle):
    - psel(addr MSB) = 1, penable = 0.
    - paddr = captured address[ADDR_WIDTH-2:0]; pwrite = ~READ_WRITE; pwdata = captured data (0 for reads).
    - Unconditionally go to ACCESS.
  - ACCESS:
    - psel held, penable = 1; paddr, pwrite and pwdata stable.
    - Only the selected slave's pready/pslverr/prdata are observed.
    - Each cycle with pready = 0 increments the timeout counter.
    - Completion, selected pready = 1: xfer_done = 1 next cycle; xfer_err = selected pslverr. A read without error loads apb_read_data_out from the selected prdata. A write, or any errored transfer, leaves apb_read_data_out unchanged.
    - Timeout, counter reaches TIMEOUT_CYCLES-1 with pready still 0: abort, xfer_done = 1, xfer_err = 1, apb_read_data_out unchanged.
    - On completion or abort: if transfer = 1, capture the new request and go directly to SETUP, with no IDLE cycle; psel drops for that one setup cycle only if the slave changes. Otherwise go to IDLE, and psel/penable fall to 0 the next cycle.
    - The timeout counter clears on entry to SETUP.
- Request timing:
  - transfer is ignored in SETUP and in non-final ACCESS cycles; requests are not queued.
  - Request inputs are sampled only at the capturing edge; later changes do not affect an in-flight transfer.
- Invariants:
  - psel1 and psel2 are never both 1.
  - penable = 1 only while one psel is 1.
- Minimum transfer is 2 cycles (SETUP + ACCESS with pready = 1).
- Address MSB fully decodes the slave; there is no invalid address.

Test Plan:
1. Reset then write: transfer=1, READ_WRITE=0, apb_write_paddr=9'h005, apb_write_data=8'hA5, pready1 tied 1 -> cycle1: psel1=1, penable=0, paddr=8'h05, pwrite=1, pwdata=8'hA5; cycle2: penable=1; then xfer_done=1, xfer_err=0; psel2 never asserted.
2. Read from slave 2: READ_WRITE=1, apb_read_paddr=9'h10F, prdata2=8'h3C, pready2 low for 3 ACCESS cycles -> psel2=1, paddr=8'h0F, pwrite=0, penable high 4 cycles; apb_read_data_out=8'h3C with xfer_done pulse.
3. Back-to-back: hold transfer=1 for a write to 9'h001 then a read from 9'h101 -> second SETUP immediately follows first ACCESS completion; psel1 falls and psel2 rises on the same edge; no IDLE cycle.
4. Timeout: pready1 held 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles; xfer_done=1 and xfer_err=1; apb_read_data_out keeps its previous value (8'h3C); FSM returns to IDLE.
5. Slave error: read with pready1=1 and pslverr1=1, prdata1=8'hFF -> xfer_err=1; apb_read_data_out unchanged.
6. Reset mid-ACCESS: presetn low while penable=1 -> psel1/psel2/penable/xfer_done go to 0 asynchronously; after release, a new transfer starts cleanly with SETUP.
